decode: RTL
===========

// Module: decode
// PURPOSE
// - Instruction decode (ID) stage of the 5-stage MIPS pipeline. Consumes fetch's IF/ID pair (PC, IR).
// - Reads/writes the register file and resolves branches/jumps in ID. Drives jump/addr back to fetch.
// - Registers operands and control into the ID/EX pipeline registers.
// - Addresses are word addresses. Fetch presents pc_if_id = address(IR)+1; the next fetched word is the delay slot.
// PARAMETERS
// - WORD_SIZE  32  datapath width; only 32 is supported
// - REG_ADDR   5   register index width (32 GPRs)
// PORTS
// - clk             in   1   single clock; all state updates on posedge
// - rst_n           in   1   synchronous, active-low reset
// - pc_if_id        in   32  IF/ID PC (address of ir_if_id + 1)
// - ir_if_id        in   32  IF/ID instruction word
// - wb_en           in   1   writeback strobe from WB stage
// - wb_reg          in   5   writeback register index
// - wb_data         in   32  writeback data
// - jump            out  1   combinational; fetch loads addr at next edge
// - addr            out  32  combinational redirect target (word address)
// - pc_id_ex        out  32  link/return address (pc_if_id + 1)
// - rs_id_ex        out  32  rs operand
// - rt_id_ex        out  32  rt operand
// - imm_id_ex       out  32  extended immediate
// - dst_id_ex       out  5   destination register
// - alu_op_id_ex    out  4   ALU operation, encoded by decode_defs.vh
// - alu_src_id_ex   out  1   1 = imm operand
// - link_id_ex      out  1   EX passes pc_id_ex as result
// - mem_rd_id_ex    out  1   load
// - mem_wr_id_ex    out  1   store
// - reg_wr_id_ex    out  1   result written back
// - illegal_id_ex   out  1   unsupported opcode/funct
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all *_id_ex outputs <= 0 (bubble); all 32 registers <= 0.
// - While rst_n=0, jump is forced to 0 combinationally.
// - Supported instructions:
//   - R-type ADDU SUBU AND OR XOR NOR SLT SLTU SLL SRL SRA JR JALR
//   - J JAL BEQ BNE ADDIU SLTI SLTIU ANDI ORI XORI LUI LW SW
//   - Anything else: NOP controls plus illegal_id_ex=1 for one cycle.
// - Register file:
//   - 2 async read ports, 1 sync write port.
//   - Writes to r0 are ignored; r0 always reads 0.
//   - Read of wb_reg while wb_en=1 bypasses wb_data (same-cycle write-then-read), except r0.
//   - No forwarding from EX/MEM and no interlock: software schedules hazards.
// - Immediate extension:
//   - Zero-extend for ANDI/ORI/XORI.
//   - {imm,16'b0} for LUI.
//   - Sign-extend otherwise.
//   - Shamt passed in imm_id_ex[4:0] for shifts.
// - Redirect (combinational from IF/ID and read data), 1 cycle of latency to fetch:
//   - BEQ/BNE taken: addr = pc_if_id + sext(imm16), modulo 2^32.
//   - J/JAL: addr = {pc_if_id[31:26], ir[25:0]}.
//   - JR/JALR: addr = rs.
//   - jump=1 only when taken; no flush. The delay-slot word in flight always executes.
// - Destination register:
//   - R-type: rd. I-type: rt. JAL: 31. JALR: rd.
//   - reg_wr_id_ex=0 when the destination register is 0.
// - Link: JAL/JALR set link_id_ex=1; pc_id_ex = pc_if_id + 1 (skips the delay slot).
// - Timing:
//   - ID/EX registers update every cycle; no stall or enable input.
//   - A writeback and a decode in the same cycle both complete.
//   - Reset asserted mid-stream discards the IF/ID content; the first post-reset cycle decodes ir_if_id=0 (SLL r0 = NOP).
// STRUCTURE
// - decode_defs.vh (shared with execute): opcode/funct localparams and ALU_* op encodings (4-bit).
// - Sub-module regfile (32x32, 2R1W, sync active-low reset, WB bypass).
// - decode holds the control decoder, extender, branch compare, target mux, and ID/EX registers.
// TESTING
// 1. rst_n=0 two cycles, ir_if_id=32'h2402_0005 -> all *_id_ex=0, jump=0; on release, ADDIU r2 decoded next edge.
// 2. wb_en=1 wb_reg=3 wb_data=32'hDEAD_BEEF with ir=ADDU r1,r3,r0 in same cycle -> rs_id_ex=32'hDEAD_BEEF, reg_wr_id_ex=1, dst=1.
// 3. r4=r5=7, BEQ r4,r5,-2 at pc_if_id=32'h10 -> jump=1, addr=32'h0E; with r5=8 -> jump=0.
// 4. JAL 26'h000_0040 at pc_if_id=32'h0400_0021 -> addr=32'h0400_0040, dst=31, link_id_ex=1, pc_id_ex=32'h0400_0022.
// 5. wb_en=1 wb_reg=0 wb_data=5, then ORI r6,r0,16'hFFFF -> rs_id_ex=0, imm_id_ex=32'h0000_FFFF.
// 6. LUI r7,16'h8001 -> imm_id_ex=32'h8001_0000; opcode 6'h3F -> illegal_id_ex=1, all write/mem controls 0.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: MIPS opcode/funct fields, ALU operation codes,
// immediate-format selector and the 16-bit sign-extension helper.
package decode_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_ADDR  = 5;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes (ir[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation encodings consumed by execute
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLT   = 4'd6;
  localparam logic [3:0] ALU_SLTU  = 4'd7;
  localparam logic [3:0] ALU_SLL   = 4'd8;
  localparam logic [3:0] ALU_SRL   = 4'd9;
  localparam logic [3:0] ALU_SRA   = 4'd10;
  localparam logic [3:0] ALU_PASSB = 4'd11;  // result = B operand (LUI)

  // How the 16-bit immediate field is widened
  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_LUI   = 2'd2,
    IMM_SHAMT = 2'd3
  } imm_sel_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, r0 hard-wired to zero, same-cycle writeback bypass on both reads.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_ADDR-1:0]  ra1_i,
  input  logic [REG_ADDR-1:0]  ra2_i,
  input  logic                 we_i,
  input  logic [REG_ADDR-1:0]  wa_i,
  input  logic [WORD_SIZE-1:0] wd_i,
  output logic [WORD_SIZE-1:0] rd1_o,
  output logic [WORD_SIZE-1:0] rd2_o
);

  localparam int NREGS = 2 ** REG_ADDR;

  logic [WORD_SIZE-1:0] regs_q [NREGS];

  // Clear every register on reset; otherwise commit the writeback (r0 never written)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // r0 reads zero; a register being written this cycle reads the incoming data
  assign rd1_o = (ra1_i == '0)                 ? '0   :
                 (we_i && (wa_i == ra1_i))     ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0)                 ? '0   :
                 (we_i && (wa_i == ra2_i))     ? wd_i : regs_q[ra2_i];

endmodule

// File: rtl/decode.sv
// MIPS ID stage: control decode, immediate extension, branch/jump
// resolution with combinational redirect to fetch, and ID/EX registers.
module decode
  import decode_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WORD_SIZE-1:0] pc_if_id,
  input  logic [WORD_SIZE-1:0] ir_if_id,
  input  logic                 wb_en,
  input  logic [REG_ADDR-1:0]  wb_reg,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 jump,
  output logic [WORD_SIZE-1:0] addr,
  output logic [WORD_SIZE-1:0] pc_id_ex,
  output logic [WORD_SIZE-1:0] rs_id_ex,
  output logic [WORD_SIZE-1:0] rt_id_ex,
  output logic [WORD_SIZE-1:0] imm_id_ex,
  output logic [REG_ADDR-1:0]  dst_id_ex,
  output logic [3:0]           alu_op_id_ex,
  output logic                 alu_src_id_ex,
  output logic                 link_id_ex,
  output logic                 mem_rd_id_ex,
  output logic                 mem_wr_id_ex,
  output logic                 reg_wr_id_ex,
  output logic                 illegal_id_ex
);

  logic [5:0]  opcode, funct;
  logic [4:0]  rs_a, rt_a, rd_a, shamt;
  logic [15:0] imm16;

  assign opcode = ir_if_id[31:26];
  assign rs_a   = ir_if_id[25:21];
  assign rt_a   = ir_if_id[20:16];
  assign rd_a   = ir_if_id[15:11];
  assign shamt  = ir_if_id[10:6];
  assign funct  = ir_if_id[5:0];
  assign imm16  = ir_if_id[15:0];

  logic [WORD_SIZE-1:0] rs_val, rt_val;

  decode_regfile #(
    .WORD_SIZE (WORD_SIZE),
    .REG_ADDR  (REG_ADDR)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1_i (rs_a),
    .ra2_i (rt_a),
    .we_i  (wb_en),
    .wa_i  (wb_reg),
    .wd_i  (wb_data),
    .rd1_o (rs_val),
    .rd2_o (rt_val)
  );

  logic [3:0]          alu_op_d;
  logic                alu_src_d, link_d, mem_rd_d, mem_wr_d, wr_req, illegal_d, reg_wr_d;
  logic [REG_ADDR-1:0] dst_d;
  imm_sel_e            imm_sel;
  logic                br_eq, br_ne, jmp_abs, jmp_reg;
  logic [WORD_SIZE-1:0] imm_d, pc_d;

  // Control decoder: NOP-shaped defaults, then per-instruction overrides
  always_comb begin
    alu_op_d  = ALU_ADD;
    alu_src_d = 1'b0;
    link_d    = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    wr_req    = 1'b0;
    illegal_d = 1'b0;
    dst_d     = rt_a;
    imm_sel   = IMM_SEXT;
    br_eq     = 1'b0;
    br_ne     = 1'b0;
    jmp_abs   = 1'b0;
    jmp_reg   = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        dst_d  = rd_a;
        wr_req = 1'b1;
        case (funct)
          FN_SLL:  begin alu_op_d = ALU_SLL; imm_sel = IMM_SHAMT; end
          FN_SRL:  begin alu_op_d = ALU_SRL; imm_sel = IMM_SHAMT; end
          FN_SRA:  begin alu_op_d = ALU_SRA; imm_sel = IMM_SHAMT; end
          FN_JR:   begin wr_req = 1'b0; jmp_reg = 1'b1; end
          FN_JALR: begin jmp_reg = 1'b1; link_d = 1'b1; end
          FN_ADDU: alu_op_d = ALU_ADD;
          FN_SUBU: alu_op_d = ALU_SUB;
          FN_AND:  alu_op_d = ALU_AND;
          FN_OR:   alu_op_d = ALU_OR;
          FN_XOR:  alu_op_d = ALU_XOR;
          FN_NOR:  alu_op_d = ALU_NOR;
          FN_SLT:  alu_op_d = ALU_SLT;
          FN_SLTU: alu_op_d = ALU_SLTU;
          default: begin wr_req = 1'b0; illegal_d = 1'b1; dst_d = '0; end
        endcase
      end
      OP_J:     jmp_abs = 1'b1;
      OP_JAL:   begin jmp_abs = 1'b1; link_d = 1'b1; wr_req = 1'b1; dst_d = 5'd31; end
      OP_BEQ:   br_eq = 1'b1;
      OP_BNE:   br_ne = 1'b1;
      OP_ADDIU: begin alu_op_d = ALU_ADD;   alu_src_d = 1'b1; wr_req = 1'b1; end
      OP_SLTI:  begin alu_op_d = ALU_SLT;   alu_src_d = 1'b1; wr_req = 1'b1; end
      OP_SLTIU: begin alu_op_d = ALU_SLTU;  alu_src_d = 1'b1; wr_req = 1'b1; end
      OP_ANDI:  begin alu_op_d = ALU_AND;   alu_src_d = 1'b1; wr_req = 1'b1; imm_sel = IMM_ZEXT; end
      OP_ORI:   begin alu_op_d = ALU_OR;    alu_src_d = 1'b1; wr_req = 1'b1; imm_sel = IMM_ZEXT; end
      OP_XORI:  begin alu_op_d = ALU_XOR;   alu_src_d = 1'b1; wr_req = 1'b1; imm_sel = IMM_ZEXT; end
      OP_LUI:   begin alu_op_d = ALU_PASSB; alu_src_d = 1'b1; wr_req = 1'b1; imm_sel = IMM_LUI; end
      OP_LW:    begin alu_op_d = ALU_ADD; alu_src_d = 1'b1; wr_req = 1'b1; mem_rd_d = 1'b1; end
      OP_SW:    begin alu_op_d = ALU_ADD; alu_src_d = 1'b1; mem_wr_d = 1'b1; end
      default:  begin illegal_d = 1'b1; dst_d = '0; end
    endcase
  end

  // A write to r0 is architecturally a no-op, so suppress it here
  assign reg_wr_d = wr_req && (dst_d != '0);
  assign pc_d     = pc_if_id + 32'd1;

  // Immediate extender
  always_comb begin
    imm_d = sext16(imm16);
    case (imm_sel)
      IMM_ZEXT:  imm_d = {16'b0, imm16};
      IMM_LUI:   imm_d = {imm16, 16'b0};
      IMM_SHAMT: imm_d = {27'b0, shamt};
      default:   imm_d = sext16(imm16);
    endcase
  end

  // Branch compare and redirect target; reset holds fetch on its own path
  always_comb begin
    jump = 1'b0;
    addr = pc_if_id + sext16(imm16);
    if (jmp_abs) addr = {pc_if_id[31:26], ir_if_id[25:0]};
    if (jmp_reg) addr = rs_val;
    if (rst_n) begin
      jump = jmp_abs || jmp_reg ||
             (br_eq && (rs_val == rt_val)) ||
             (br_ne && (rs_val != rt_val));
    end
  end

  // ID/EX pipeline registers: bubble on reset, otherwise capture every cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_id_ex      <= '0;
      rs_id_ex      <= '0;
      rt_id_ex      <= '0;
      imm_id_ex     <= '0;
      dst_id_ex     <= '0;
      alu_op_id_ex  <= '0;
      alu_src_id_ex <= 1'b0;
      link_id_ex    <= 1'b0;
      mem_rd_id_ex  <= 1'b0;
      mem_wr_id_ex  <= 1'b0;
      reg_wr_id_ex  <= 1'b0;
      illegal_id_ex <= 1'b0;
    end else begin
      pc_id_ex      <= pc_d;
      rs_id_ex      <= rs_val;
      rt_id_ex      <= rt_val;
      imm_id_ex     <= imm_d;
      dst_id_ex     <= dst_d;
      alu_op_id_ex  <= alu_op_d;
      alu_src_id_ex <= alu_src_d;
      link_id_ex    <= link_d;
      mem_rd_id_ex  <= mem_rd_d;
      mem_wr_id_ex  <= mem_wr_d;
      reg_wr_id_ex  <= reg_wr_d;
      illegal_id_ex <= illegal_d;
    end
  end

endmodule
